// File: rtl/scp_mem_pkg.sv
// Shared definitions for the main-RAM arbitration slice: default widths,
// lock state encoding and requester port ids.
package scp_mem_pkg;

  localparam int DEF_ADDR_W   = 16;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_LOCK_MAX = 64;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKED0  = 2'd1,
    LOCKED1  = 2'd2
  } lock_state_t;

  // Ports allowed to compete for the grant in a given lock state.
  function automatic logic [1:0] lock_mask(input lock_state_t s);
    case (s)
      UNLOCKED: return 2'b11;
      LOCKED0:  return 2'b01;
      LOCKED1:  return 2'b10;
      default:  return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way round-robin pick: among eligible requesters, the one not granted
// most recently wins a tie.
module rr_arb2
  import scp_mem_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       rr_last,
  input  logic [1:0] mask,
  output logic [1:0] grant
);

  logic [1:0] elig;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    elig  = valid & mask;
    grant = elig;
    if (elig == 2'b11) begin
      grant            = 2'b00;
      grant[PORT_CPU]  = (rr_last == PORT_DMA);
      grant[PORT_DMA]  = (rr_last == PORT_CPU);
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single-port main RAM between CPU (port 0) and DMA/video (port 1):
// round-robin grant, read-modify-write lock with idle timeout, read return.
module ram_arbiter
  import scp_mem_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int LOCK_MAX = DEF_LOCK_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req0_we,
  input  logic              req0_lock,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  input  logic              req1_we,
  input  logic              req1_lock,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q,
  output logic              lock_timeout
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  lock_state_t       state_q, state_d;
  logic [CNT_W-1:0]  idle_cnt_q, idle_cnt_d;
  logic              rr_last_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rd_pend_q, rd_port_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  logic [1:0]        valid, mask, grant;
  logic              any_gnt, gnt_port, g_we, g_lock, timeout;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;

  // Reset masks both ports so nothing is accepted or written in that cycle.
  assign valid = {req1_valid, req0_valid};
  assign mask  = rst ? 2'b00 : lock_mask(state_q);

  rr_arb2 u_rr_arb2 (
    .valid   (valid),
    .rr_last (rr_last_q),
    .mask    (mask),
    .grant   (grant)
  );

  assign any_gnt    = |grant;
  assign gnt_port   = grant[PORT_DMA];
  assign req0_ready = grant[PORT_CPU];
  assign req1_ready = grant[PORT_DMA];

  always_comb begin
    g_addr  = req0_addr;
    g_wdata = req0_wdata;
    g_we    = req0_we;
    g_lock  = req0_lock;
    if (gnt_port == PORT_DMA) begin
      g_addr  = req1_addr;
      g_wdata = req1_wdata;
      g_we    = req1_we;
      g_lock  = req1_lock;
    end
  end

  assign ram_addr = any_gnt ? g_addr : addr_q;
  assign ram_data = g_wdata;
  assign ram_we   = any_gnt & g_we;

  // While locked only the owner can be granted, so any grant is an owner accept.
  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    timeout    = 1'b0;
    if (any_gnt) begin
      state_d    = g_lock ? ((gnt_port == PORT_DMA) ? LOCKED1 : LOCKED0) : UNLOCKED;
      idle_cnt_d = '0;
    end else if (!rst && state_q != UNLOCKED) begin
      if (idle_cnt_q == CNT_W'(LOCK_MAX - 1)) begin
        state_d    = UNLOCKED;
        idle_cnt_d = '0;
        timeout    = 1'b1;
      end else begin
        idle_cnt_d = idle_cnt_q + CNT_W'(1);
      end
    end
  end

  assign lock_timeout = timeout;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= UNLOCKED;
      idle_cnt_q <= '0;
      rr_last_q  <= PORT_DMA;
      addr_q     <= '0;
      rd_pend_q  <= 1'b0;
      rd_port_q  <= PORT_CPU;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      if (any_gnt) begin
        rr_last_q <= gnt_port;
        addr_q    <= g_addr;
      end
      rd_pend_q <= any_gnt & ~g_we;
      rd_port_q <= gnt_port;
      if (rsp0_valid) rdata0_q <= ram_q;
      if (rsp1_valid) rdata1_q <= ram_q;
    end
  end

  // A response still in flight when reset arrives is dropped immediately.
  assign rsp0_valid = !rst && rd_pend_q && (rd_port_q == PORT_CPU);
  assign rsp1_valid = !rst && rd_pend_q && (rd_port_q == PORT_DMA);
  assign rsp0_rdata = rsp0_valid ? ram_q : rdata0_q;
  assign rsp1_rdata = rsp1_valid ? ram_q : rdata1_q;

  a_req0_stable: assert property (@(posedge clk)
    (req0_valid && !req0_ready && !rst) |=>
      (req0_valid && $stable({req0_addr, req0_wdata, req0_we, req0_lock})))
    else $error("req0 changed while stalled");

  a_req1_stable: assert property (@(posedge clk)
    (req1_valid && !req1_ready && !rst) |=>
      (req1_valid && $stable({req1_addr, req1_wdata, req1_we, req1_lock})))
    else $error("req1 changed while stalled");

endmodule
